cp0_intc: RTL and testbench

- Coprocessor-0 style interrupt/exception controller that sits directly downstream of the timer and other bus devices.
- Collects their IRQ lines as HWInt[5:0], along with the CPU pipeline's exception code and PC.
- Decides when the CPU must trap and records the trap context in the SR, Cause and EPC registers.
- Gives software read/write access to those registers through the mfc0/mtc0 datapath.

---
 rtl/cp0_intc.sv | 139 +++++++++++++
 tb/tb_cp0_intc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - coprocessor-0 interrupt/exception controller
//
// Collects device IRQs and pipeline exception codes, decides when the CPU
// must trap, and records the trap context in SR, Cause and EPC. Software
// reads these registers through mfc0 and writes them through mtc0.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   A1      - mfc0 read register select
//   A2      - mtc0 write register select
//   DIn     - mtc0 write data
//   WE      - mtc0 write enable
//   PC      - PC of the instruction in the commit stage
//   BDIn    - commit-stage instruction sits in a branch delay slot
//   ExcCode - pipeline exception code, 0 = none
//   HWInt   - level-sensitive device IRQs, bit 0 is the timer
//   EXLClr  - eret commit, clears SR.EXL
//   Req     - trap request to the pipeline (combinational)
//   EPCOut  - current EPC, eret target
//   DOut    - mfc0 read data (combinational on A1)

module cp0_intc #(
  parameter logic [31:0] PRID   = 32'h4D49_5053,
  parameter int          HWBITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        A1,
  input  logic [4:0]        A2,
  input  logic [31:0]       DIn,
  input  logic              WE,
  input  logic [31:0]       PC,
  input  logic              BDIn,
  input  logic [4:0]        ExcCode,
  input  logic [HWBITS-1:0] HWInt,
  input  logic              EXLClr,
  output logic              Req,
  output logic [31:0]       EPCOut,
  output logic [31:0]       DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [HWBITS-1:0] sr_im;
  logic              sr_exl;
  logic              sr_ie;

  // Cause fields
  logic              cause_bd;
  logic [HWBITS-1:0] cause_ip;
  logic [4:0]        cause_exc;

  // EPC is word aligned, so only the upper 30 bits are stored
  logic [29:0]       epc_hi;

  logic              int_req;
  logic              exc_req;
  logic [31:0]       trap_pc;
  logic [31:0]       sr_word;
  logic [31:0]       cause_word;
  logic [31:0]       epc_word;
  logic [1:0]        unused_pc_bits;

  always_comb begin
    int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_req = (ExcCode != 5'd0) & ~sr_exl;
    // Gate with reset so a pending exception code cannot raise Req while
    // the controller is being held in reset.
    Req     = ~reset & (int_req | exc_req);
  end

  // A delay-slot instruction restarts at the branch; wraps modulo 2^32.
  assign trap_pc        = BDIn ? (PC - 32'd4) : PC;
  assign unused_pc_bits = trap_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc_hi    <= 30'd0;
    end else begin
      cause_ip <= HWInt;
      if (int_req || exc_req) begin
        // A trap discards any mtc0 or eret in the same cycle.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCode;
        cause_bd  <= BDIn;
        epc_hi    <= trap_pc[31:2];
      end else begin
        if (WE && (A2 == REG_SR)) begin
          sr_im  <= DIn[15:10];
          sr_exl <= DIn[1];
          sr_ie  <= DIn[0];
        end
        if (WE && (A2 == REG_EPC)) begin
          epc_hi <= DIn[31:2];
        end
        // Later assignment wins: eret overrides the EXL bit of an SR write.
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word        = 32'd0;
    sr_word[15:10] = sr_im;
    sr_word[1]     = sr_exl;
    sr_word[0]     = sr_ie;

    cause_word        = 32'd0;
    cause_word[31]    = cause_bd;
    cause_word[15:10] = cause_ip;
    cause_word[6:2]   = cause_exc;

    epc_word = {epc_hi, 2'b00};

    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_word;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign EPCOut = epc_word;

endmodule

// File: tb/tb_cp0_intc.sv
// tb/tb_cp0_intc.sv - self-checking bench for cp0_intc
module tb_cp0_intc;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register words
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_intc dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BDIn(BDIn), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_int_req();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_exc_req();
    return (ExcCode != 5'd0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h4D49_5053;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  task automatic model_edge();
    bit ir;
    bit er;
    ir = m_int_req();
    er = m_exc_req();
    if (ir || er) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (BDIn ? 32'h8000_0000 : 32'd0) | (32'(HWInt) << 10)
              | (ir ? 32'd0 : (32'(ExcCode) << 2));
      m_epc   = (BDIn ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
    end else begin
      if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
      if (WE && A2 == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
      if (EXLClr) m_sr = m_sr & ~32'h2;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
    end
  endtask

  // Check outputs against the model mid-cycle, then advance one edge.
  task automatic tick();
    @(negedge clk);
    check("req_model", {31'd0, Req}, {31'd0, (m_int_req() || m_exc_req())});
    check("epcout_model", EPCOut, m_epc);
    check("dout_model", DOut, m_read(A1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    A1 = a;
    #1;
    check(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; PC = 32'd0;
    BDIn = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    model_reset();
    #3;
    rd(5'd12, 32'd0, "reset_sr");
    rd(5'd13, 32'd0, "reset_cause");
    rd(5'd14, 32'd0, "reset_epc");
    rd(5'd15, 32'h4D49_5053, "reset_prid");
    check("reset_req", {31'd0, Req}, 32'd0);
    check("reset_epcout", EPCOut, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Timer interrupt
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    WE = 1'b0; HWInt = 6'b000001; PC = 32'h0000_3010;
    #1;
    check("timer_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd12, 32'h0000_0403, "timer_sr");
    rd(5'd13, 32'h0000_0400, "timer_cause");
    rd(5'd14, 32'h0000_3010, "timer_epc");
    check("timer_req_after", {31'd0, Req}, 32'd0);
    check("timer_epcout", EPCOut, 32'h0000_3010);

    // Masking while EXL is set, then eret
    HWInt = 6'd0; ExcCode = 5'd5;
    #1;
    check("mask_exc", {31'd0, Req}, 32'd0);
    tick();
    HWInt = 6'd1; ExcCode = 5'd0;
    #1;
    check("mask_int", {31'd0, Req}, 32'd0);
    tick();
    EXLClr = 1'b1;
    #1;
    check("eret_cycle_req", {31'd0, Req}, 32'd0);
    tick();
    EXLClr = 1'b0;
    #1;
    check("after_eret_req", {31'd0, Req}, 32'd1);
    tick();

    // Drop EXL and IE together
    WE = 1'b1; A2 = 5'd12; DIn = 32'd0; HWInt = 6'd0;
    tick();
    WE = 1'b0;

    // Delay-slot exception
    ExcCode = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
    #1;
    check("ds_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd14, 32'h0000_3020, "ds_epc");
    rd(5'd13, 32'h8000_0030, "ds_cause");
    ExcCode = 5'd0; BDIn = 1'b0;

    // Re-enable timer interrupt (write SR while EXL=1 clears EXL from DIn)
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();

    // Simultaneous interrupt, exception and mtc0 EPC
    A2 = 5'd14; DIn = 32'h0000_1234; HWInt = 6'd1; ExcCode = 5'd4; PC = 32'h0000_5000;
    #1;
    check("sim_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd13, 32'h0000_0400, "sim_cause");
    rd(5'd14, 32'h0000_5000, "sim_epc");
    ExcCode = 5'd0;

    // Register writes
    A2 = 5'd12; DIn = 32'h0000_0400;
    tick();
    A2 = 5'd14; DIn = 32'h0000_4007;
    tick();
    rd(5'd14, 32'h0000_4004, "wr_epc");
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    rd(5'd13, 32'h0000_0400, "wr_cause_ro");
    rd(5'd3, 32'd0, "unmapped_read");
    WE = 1'b0;

    // EPC wrap on PC = 0 in a delay slot
    ExcCode = 5'd1; BDIn = 1'b1; PC = 32'd0;
    #1;
    check("wrap_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");
    ExcCode = 5'd0; BDIn = 1'b0; HWInt = 6'd0;
    WE = 1'b1; A2 = 5'd12; DIn = 32'd0;
    tick();
    WE = 1'b0;

    // Reset mid-cycle drops a pending request immediately
    ExcCode = 5'd3;
    #1;
    check("pre_reset_req", {31'd0, Req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_req", {31'd0, Req}, 32'd0);
    rd(5'd13, 32'd0, "async_reset_cause");
    rd(5'd14, 32'd0, "async_reset_epc");
    check("async_reset_epcout", EPCOut, 32'd0);
    ExcCode = 5'd0;
    model_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      A1      = 5'($urandom_range(10, 16));
      A2      = ($urandom % 2 == 0) ? (($urandom % 2 == 0) ? 5'd12 : 5'd14) : 5'($urandom);
      WE      = ($urandom % 3 == 0);
      DIn     = $urandom;
      PC      = $urandom;
      BDIn    = 1'($urandom);
      ExcCode = ($urandom % 4 == 0) ? 5'($urandom) : 5'd0;
      HWInt   = 6'($urandom);
      EXLClr  = ($urandom % 4 == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
